uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver: the stage directly downstream of the team's UART transmitter. It deserialises the line produced by that transmitter, or by any external device with the same frame format.
- Frame format, in line order: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
- Each received word is presented on a one-cycle valid strobe, together with parity and framing status.
- Sits between the external rx pin and the receive-side buffer or consumer logic.

Parameters:
- DATA_WIDTH, 8, data bits per frame (1..16).
- STOP_BITS, 1, stop bits expected (1 or 2); every stop bit is checked.
- PARITY, 1, 1 = parity bit present and checked; 0 = no parity bit.
- EVEN, 1, 1 = even parity (parity bit = XOR of data bits); 0 = odd (XNOR).
- PRESCALER, 15, clk cycles per bit period; must be >= 4. Must equal the transmitter's PRESCALER for a loopback link.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- rx  input  1  serial line, asynchronous to clk, idles high.
- rxd  output  DATA_WIDTH  last received data word, LSB = first data bit on the line.
- rxv  output  1  one-cycle strobe: rxd, parity_err and frame_err are updated this cycle.
- parity_err  output  1  parity mismatch on the last frame; always 0 when PARITY=0.
- frame_err  output  1  at least one stop bit of the last frame sampled 0.
- active  output  1  high while a frame is being received (every state except IDLE).

Behaviour:
- Reset (async, rst=1):
  - Outputs: rxd=0, rxv=0, parity_err=0, frame_err=0, active=0.
  - Internal: state=IDLE, synchroniser flops=1, counters=0.
- Synchroniser: rx passes through 2 flops to give rx_s. All decoding uses rx_s only. A third flop holds rx_s_d for edge detection.
- Bit counter: ctr counts 0..PRESCALER-1 while active and is held at 0 in IDLE. Mid = PRESCALER/2 - 1, using integer division.
- IDLE:
  - A falling edge (rx_s_d=1, rx_s=0) moves to START with ctr=0.
  - A line held low never retriggers; a fresh 1->0 transition is required.
- START:
  - At ctr==Mid, sample rx_s.
  - If 1: false start, return to IDLE with no rxv and no status change.
  - If 0: ctr<=0, go to DATA with bit index=0. From here on, every sample is taken when ctr==PRESCALER-1, which is the mid-bit point.
- DATA:
  - Each sample is shifted into a shift register, LSB first.
  - After the DATA_WIDTH-th sample, go to PAR if PARITY=1, otherwise to STOP.
- PAR: one sample, compared with the expected parity (XOR of data, inverted when EVEN=0). A mismatch sets an internal perr flag.
- STOP:
  - Take STOP_BITS samples; any 0 sets an internal ferr flag.
  - After the final stop sample, go directly to IDLE. Do not wait for the end of the bit, so the next start edge can be caught as early as possible.
- Output update: on the cycle after the final stop sample:
  - rxv=1 for exactly 1 cycle;
  - rxd <= shift register; parity_err <= perr; frame_err <= ferr.
  - Data is delivered even when an error flag is set.
  - rxd and the error flags then hold until the next rxv.
- active: high from the cycle after the start edge is detected until the cycle rxv asserts (inclusive), then low.
- Latency (PRESCALER=15, DATA_WIDTH=8, PARITY=1, STOP_BITS=1): rxv asserts 2 (sync) + 1 (edge) + 7 (Mid+1) + 10x15 + 1 clk after the rx falling edge, with ±1 cycle for async sampling.
- Back-to-back frames: a start edge arriving in the first IDLE cycle after the stop sample is accepted; no gap cycles are required.
- Break or stuck-low line: each frame sets frame_err=1. After that, no further frames are received until rx returns high and then falls again.
- Reset mid-frame: the frame is discarded, no rxv, and all outputs return to their reset values immediately.
- No back-pressure: the consumer must capture rxd on rxv. A new frame overwrites rxd without notice.

Test Plan:
- Glitch rejection: rx low for 4 clk, then high (PRESCALER=15) -> active goes high then low again; rxv never asserts; rxd stays 0.
- Clean frame: send 0xA5 at 15 clk/bit with even parity (parity bit 0) and one stop bit -> one rxv pulse; rxd=0xA5, parity_err=0, frame_err=0; active low the cycle after rxv.
- Parity error: send 0xA5 with parity bit 1 -> rxd=0xA5, parity_err=1, frame_err=0. Next clean frame 0x3C (parity 0) -> parity_err returns to 0.
- Frame error: send 0x00 with stop bit 0, hold rx low for 30 clk, release high, then send 0x5A -> first rxv has frame_err=1; no extra rxv while the line is low; second rxv has rxd=0x5A, frame_err=0.
- Reset mid-frame: assert rst for 1 clk during data bit 3 of 0xFF -> active=0 and rxv=0 immediately; the following frame 0x81 is received correctly.
- Loopback with the transmitter (same parameters): 256 back-to-back words 0x00..0xFF with txv held high -> 256 rxv pulses, in-order match, no error flags.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling, LSB-first data,
// optional parity, 1..2 checked stop bits, one-cycle rxv strobe with status.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 1,
  parameter int EVEN       = 1,
  parameter int PRESCALER  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rxd,
  output logic                  rxv,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  active
);

  localparam int CW = $clog2(PRESCALER);
  localparam int IW = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0] MID     = CW'(PRESCALER / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(PRESCALER - 1);
  localparam logic [IW-1:0] DLAST   = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] SLAST   = IW'(STOP_BITS - 1);
  localparam logic          PAR_INV = (EVEN == 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t                  state;
  logic                    rx_m;
  logic                    rx_s;
  logic                    rx_s_d;
  logic [CW-1:0]           ctr;
  logic [IW-1:0]           idx;
  logic [DATA_WIDTH-1:0]   shreg;
  logic [DATA_WIDTH-1:0]   shreg_next;
  logic                    perr;
  logic                    ferr;
  logic                    fall;
  logic                    tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
    end
  end

  assign fall = rx_s_d & ~rx_s;
  assign tick = (ctr == LAST);

  // Shift form avoids a zero-width slice when DATA_WIDTH is 1.
  assign shreg_next = (shreg >> 1) | (DATA_WIDTH'(rx_s) << (DATA_WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ctr        <= '0;
      idx        <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      rxd        <= '0;
      rxv        <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rxv <= 1'b0;
      case (state)
        IDLE: begin
          ctr <= '0;
          if (fall) begin
            state <= START;
            idx   <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
          end
        end
        START: begin
          if (ctr == MID) begin
            ctr   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            ctr   <= '0;
            shreg <= shreg_next;
            if (idx == DLAST) begin
              idx   <= '0;
              state <= (PARITY != 0) ? PAR : STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        PAR: begin
          if (tick) begin
            ctr   <= '0;
            perr  <= rx_s ^ (^shreg) ^ PAR_INV;
            state <= STOP;
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            ctr <= '0;
            if (idx == SLAST) begin
              // Leave on the final stop sample so a following start edge is not missed.
              idx        <= '0;
              state      <= IDLE;
              rxv        <= 1'b1;
              rxd        <= shreg;
              parity_err <= perr;
              frame_err  <= ferr | ~rx_s;
            end else begin
              idx  <= idx + 1'b1;
              ferr <= ferr | ~rx_s;
            end
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ctr   <= '0;
        end
      endcase
    end
  end

  assign active = (state != IDLE) | rxv;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8 data bits, even parity, 1 stop bit, 15 clk/bit.
module tb_uart_rx;

  localparam int P = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rxd;
  logic       rxv;
  logic       parity_err;
  logic       frame_err;
  logic       active;

  uart_rx #(
    .DATA_WIDTH(8),
    .STOP_BITS (1),
    .PARITY    (1),
    .EVEN      (1),
    .PRESCALER (P)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rxd       (rxd),
    .rxv       (rxv),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .active    (active)
  );

  always #5 clk = ~clk;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  int          cyc       = 0;
  int          t_start   = 0;
  logic        prev_rxv  = 1'b0;

  logic [7:0] q_d[$];
  logic       q_pe[$];
  logic       q_fe[$];
  int         q_cyc[$];
  logic       q_act[$];

  // Capture every rxv strobe, plus active on the cycle after it.
  always @(negedge clk) begin
    if (prev_rxv) q_act.push_back(active);
    if (rxv === 1'b1) begin
      q_d.push_back(rxd);
      q_pe.push_back(parity_err);
      q_fe.push_back(frame_err);
      q_cyc.push_back(cyc);
    end
    prev_rxv = rxv;
    cyc++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic clear_q();
    q_d.delete();
    q_pe.delete();
    q_fe.delete();
    q_cyc.delete();
    q_act.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    idle(P);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    t_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stp);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    idle(3);
    total_cnt++; if (rxd !== 8'h00) $display("FAIL reset_rxd: got %h want 00", rxd); else pass_cnt++;
    total_cnt++; if (rxv !== 1'b0) $display("FAIL reset_rxv: got %b want 0", rxv); else pass_cnt++;
    total_cnt++; if (parity_err !== 1'b0) $display("FAIL reset_perr: got %b want 0", parity_err); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_err); else pass_cnt++;
    total_cnt++; if (active !== 1'b0) $display("FAIL reset_active: got %b want 0", active); else pass_cnt++;
    rst = 1'b0;
    idle(3);
  endtask

  task automatic test_glitch();
    logic saw;
    saw = 1'b0;
    clear_q();
    rx = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 4) rx = 1'b1;
      idle(1);
      if (active === 1'b1) saw = 1'b1;
    end
    total_cnt++; if (saw !== 1'b1) $display("FAIL glitch_active_seen: got %b want 1", saw); else pass_cnt++;
    total_cnt++; if (active !== 1'b0) $display("FAIL glitch_active_end: got %b want 0", active); else pass_cnt++;
    total_cnt++; if (q_d.size() != 0) $display("FAIL glitch_rxv_count: got %0d want 0", q_d.size()); else pass_cnt++;
    total_cnt++; if (rxd !== 8'h00) $display("FAIL glitch_rxd: got %h want 00", rxd); else pass_cnt++;
  endtask

  task automatic test_clean();
    logic [7:0] d;
    logic       pe, fe, act;
    int         lat;
    clear_q();
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(10);
    d   = (q_d.size() > 0) ? q_d[0] : 8'hxx;
    pe  = (q_pe.size() > 0) ? q_pe[0] : 1'bx;
    fe  = (q_fe.size() > 0) ? q_fe[0] : 1'bx;
    act = (q_act.size() > 0) ? q_act[0] : 1'bx;
    lat = (q_cyc.size() > 0) ? q_cyc[0] - t_start : -1;
    total_cnt++; if (q_d.size() != 1) $display("FAIL clean_count: got %0d want 1", q_d.size()); else pass_cnt++;
    total_cnt++; if (d !== 8'hA5) $display("FAIL clean_rxd: got %h want a5", d); else pass_cnt++;
    total_cnt++; if (pe !== 1'b0) $display("FAIL clean_perr: got %b want 0", pe); else pass_cnt++;
    total_cnt++; if (fe !== 1'b0) $display("FAIL clean_ferr: got %b want 0", fe); else pass_cnt++;
    total_cnt++; if (act !== 1'b0) $display("FAIL clean_active_after: got %b want 0", act); else pass_cnt++;
    total_cnt++;
    if (lat < 160 || lat > 162) $display("FAIL clean_latency: got %0d want 160..162", lat);
    else pass_cnt++;
  endtask

  task automatic test_parity();
    clear_q();
    send_frame(8'hA5, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(10);
    total_cnt++; if (q_d.size() != 2) $display("FAIL par_count: got %0d want 2", q_d.size()); else pass_cnt++;
    if (q_d.size() < 2) begin
      q_d.push_back(8'hxx); q_d.push_back(8'hxx);
      q_pe.push_back(1'bx); q_pe.push_back(1'bx);
      q_fe.push_back(1'bx); q_fe.push_back(1'bx);
    end
    total_cnt++; if (q_d[0] !== 8'hA5) $display("FAIL par_rxd0: got %h want a5", q_d[0]); else pass_cnt++;
    total_cnt++; if (q_pe[0] !== 1'b1) $display("FAIL par_perr0: got %b want 1", q_pe[0]); else pass_cnt++;
    total_cnt++; if (q_fe[0] !== 1'b0) $display("FAIL par_ferr0: got %b want 0", q_fe[0]); else pass_cnt++;
    total_cnt++; if (q_d[1] !== 8'h3C) $display("FAIL par_rxd1: got %h want 3c", q_d[1]); else pass_cnt++;
    total_cnt++; if (q_pe[1] !== 1'b0) $display("FAIL par_perr1: got %b want 0", q_pe[1]); else pass_cnt++;
    total_cnt++; if (q_fe[1] !== 1'b0) $display("FAIL par_ferr1: got %b want 0", q_fe[1]); else pass_cnt++;
  endtask

  task automatic test_frame_err();
    clear_q();
    send_frame(8'h00, 1'b0, 1'b0);
    idle(30);
    rx = 1'b1;
    idle(2 * P);
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(10);
    total_cnt++; if (q_d.size() != 2) $display("FAIL ferr_count: got %0d want 2", q_d.size()); else pass_cnt++;
    if (q_d.size() < 2) begin
      q_d.push_back(8'hxx); q_d.push_back(8'hxx);
      q_pe.push_back(1'bx); q_pe.push_back(1'bx);
      q_fe.push_back(1'bx); q_fe.push_back(1'bx);
    end
    total_cnt++; if (q_d[0] !== 8'h00) $display("FAIL ferr_rxd0: got %h want 00", q_d[0]); else pass_cnt++;
    total_cnt++; if (q_fe[0] !== 1'b1) $display("FAIL ferr_ferr0: got %b want 1", q_fe[0]); else pass_cnt++;
    total_cnt++; if (q_pe[0] !== 1'b0) $display("FAIL ferr_perr0: got %b want 0", q_pe[0]); else pass_cnt++;
    total_cnt++; if (q_d[1] !== 8'h5A) $display("FAIL ferr_rxd1: got %h want 5a", q_d[1]); else pass_cnt++;
    total_cnt++; if (q_fe[1] !== 1'b0) $display("FAIL ferr_ferr1: got %b want 0", q_fe[1]); else pass_cnt++;
    total_cnt++; if (q_pe[1] !== 1'b0) $display("FAIL ferr_perr1: got %b want 0", q_pe[1]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic       pe, fe;
    clear_q();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    rx = 1'b1;
    idle(7);
    rst = 1'b1;
    #1;
    total_cnt++; if (active !== 1'b0) $display("FAIL rstmid_active: got %b want 0", active); else pass_cnt++;
    total_cnt++; if (rxv !== 1'b0) $display("FAIL rstmid_rxv: got %b want 0", rxv); else pass_cnt++;
    total_cnt++; if (rxd !== 8'h00) $display("FAIL rstmid_rxd: got %h want 00", rxd); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL rstmid_ferr: got %b want 0", frame_err); else pass_cnt++;
    idle(1);
    rst = 1'b0;
    idle(8 * P);
    total_cnt++; if (q_d.size() != 0) $display("FAIL rstmid_no_rxv: got %0d want 0", q_d.size()); else pass_cnt++;
    send_frame(8'h81, 1'b0, 1'b1);
    idle(10);
    d  = (q_d.size() > 0) ? q_d[0] : 8'hxx;
    pe = (q_pe.size() > 0) ? q_pe[0] : 1'bx;
    fe = (q_fe.size() > 0) ? q_fe[0] : 1'bx;
    total_cnt++; if (q_d.size() != 1) $display("FAIL rstmid_count: got %0d want 1", q_d.size()); else pass_cnt++;
    total_cnt++; if (d !== 8'h81) $display("FAIL rstmid_rxd_next: got %h want 81", d); else pass_cnt++;
    total_cnt++; if ({pe, fe} !== 2'b00) $display("FAIL rstmid_flags: got %b want 00", {pe, fe}); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    logic [9:0] got;
    clear_q();
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      send_frame(b, ^b, 1'b1);
    end
    idle(10);
    total_cnt++; if (q_d.size() != 256) $display("FAIL b2b_count: got %0d want 256", q_d.size()); else pass_cnt++;
    for (int i = 0; i < 256; i++) begin
      b   = 8'(i);
      got = (i < q_d.size()) ? {q_d[i], q_pe[i], q_fe[i]} : 10'bx;
      total_cnt++;
      if (got !== {b, 2'b00}) $display("FAIL b2b_word%0d: got %h want %h", i, got, {b, 2'b00});
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    test_reset();
    test_glitch();
    test_clean();
    test_parity();
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
